// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer for
// decode stalls, and redirect handling that drains an outstanding memory request.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_4
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_4_q, id_pc_4_d;

  logic [31:0] redir_aligned;
  logic [31:0] addr_inc;

  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign addr_inc      = addr_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      addr_q      <= RESET_PC;
      redir_q     <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      id_pc_4_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      redir_q     <= redir_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc_4_q   <= id_pc_4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect)
          state_d = imem_ack ? FETCH : DRAIN;
        else if (imem_ack && stall)
          state_d = HOLD;
      end
      HOLD: begin
        if (redirect || !stall)
          state_d = FETCH;
      end
      DRAIN: begin
        if (imem_ack)
          state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Redirect outranks stall in every state; leaving HOLD implicitly discards the skid.
  always_comb begin
    addr_d      = addr_q;
    redir_d     = redir_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc_4_d   = id_pc_4_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          id_inst_d  = '0;
          if (imem_ack) addr_d  = redir_aligned;
          else          redir_d = redir_aligned;
        end else if (imem_ack) begin
          addr_d = addr_inc;
          if (stall) begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = addr_q;
          end else begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata;
            id_pc_d    = addr_q;
            id_pc_4_d  = addr_inc;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          id_inst_d  = '0;
          addr_d     = redir_aligned;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_inst_d  = skid_inst_q;
          id_pc_d    = skid_pc_q;
          id_pc_4_d  = skid_pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          id_inst_d  = '0;
          redir_d    = redir_aligned;
          if (imem_ack) addr_d = redir_aligned;
        end else if (imem_ack) begin
          addr_d = redir_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req  = !rst && (state_q != HOLD);
    imem_addr = addr_q;
    id_valid  = id_valid_q;
    id_inst   = id_inst_q;
    id_pc     = id_pc_q;
    id_pc_4   = id_pc_4_q;
  end

endmodule
